// File: rtl/pulp_boot_ctrl.sv
// PULPino bring-up sequencer for the FPGA emulator.
// Runs in the ps7_clk domain. It holds the SoC in reset, waits for the clock
// generator to lock, debounces the PS fetch request and drives fetch enable.
// It then watches end-of-computation, captures the return code and counts run
// cycles into the status word read by the PS.
module pulp_boot_ctrl #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 1024,
    parameter int DEB_CYCLES      = 32
) (
    input  logic        ps7_clk,
    input  logic        ps7_rst_n,
    input  logic [31:0] ctrl_i,
    input  logic        clk_locked_i,
    input  logic        eoc_i,
    input  logic [1:0]  return_i,
    output logic        pulp_rst_no,
    output logic        fetch_en_o,
    output logic [31:0] status_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_HOLD  = 3'd1,
        WAIT_LOCK = 3'd2,
        READY     = 3'd3,
        RUN       = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    // Terminal count values for the shared phase counter
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] DEB_LAST  = 32'(DEB_CYCLES - 1);

    state_t      state;
    logic [31:0] cnt;        // phase counter: reset hold, lock wait, debounce
    logic [15:0] run_cnt;    // saturating run-cycle counter
    logic        eoc_done;
    logic [1:0]  ret_code;
    logic        lock_tmo;
    logic        lock_lost;
    logic        eoc_q1;
    logic        eoc_s;

    // Two-flop synchroniser for the asynchronous end-of-computation flag
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            eoc_q1 <= 1'b0;
            eoc_s  <= 1'b0;
        end else begin
            eoc_q1 <= eoc_i;
            eoc_s  <= eoc_q1;
        end
    end

    // Boot sequencer FSM with registered outputs and captured status fields
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            run_cnt     <= '0;
            eoc_done    <= 1'b0;
            ret_code    <= 2'b00;
            lock_tmo    <= 1'b0;
            lock_lost   <= 1'b0;
            pulp_rst_no <= 1'b0;
            fetch_en_o  <= 1'b0;
        end else begin
            // Status clear; any capture below in the same cycle overrides it
            if (ctrl_i[1]) begin
                eoc_done  <= 1'b0;
                ret_code  <= 2'b00;
                lock_tmo  <= 1'b0;
                lock_lost <= 1'b0;
                run_cnt   <= '0;
            end

            if (!ctrl_i[31]) begin
                // Abort from anywhere: back to reset, captured bits survive
                state       <= IDLE;
                cnt         <= '0;
                pulp_rst_no <= 1'b0;
                fetch_en_o  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        pulp_rst_no <= 1'b0;
                        fetch_en_o  <= 1'b0;
                        cnt         <= '0;
                        state       <= RST_HOLD;
                    end
                    RST_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt   <= '0;
                            state <= WAIT_LOCK;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (clk_locked_i) begin
                            cnt         <= '0;
                            pulp_rst_no <= 1'b1;
                            state       <= READY;
                        end else if (cnt == LOCK_LAST) begin
                            cnt      <= '0;
                            lock_tmo <= 1'b1;
                            state    <= ERROR;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    READY: begin
                        // eoc_s deliberately ignored until the core is fetching
                        if (ctrl_i[0]) begin
                            if (cnt == DEB_LAST) begin
                                cnt        <= '0;
                                run_cnt    <= '0;
                                fetch_en_o <= 1'b1;
                                state      <= RUN;
                            end else begin
                                cnt <= cnt + 32'd1;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    RUN: begin
                        // Lock loss outranks a simultaneous end-of-computation
                        if (!clk_locked_i) begin
                            lock_lost   <= 1'b1;
                            run_cnt     <= run_cnt;
                            fetch_en_o  <= 1'b0;
                            pulp_rst_no <= 1'b0;
                            state       <= ERROR;
                        end else if (eoc_s) begin
                            eoc_done   <= 1'b1;
                            ret_code   <= return_i;
                            run_cnt    <= run_cnt;
                            fetch_en_o <= 1'b0;
                            state      <= DONE;
                        end else if (!ctrl_i[1] && run_cnt != 16'hFFFF) begin
                            run_cnt <= run_cnt + 16'd1;
                        end
                    end
                    DONE: begin
                        pulp_rst_no <= 1'b1;
                        fetch_en_o  <= 1'b0;
                    end
                    ERROR: begin
                        pulp_rst_no <= 1'b0;
                        fetch_en_o  <= 1'b0;
                    end
                    default: begin
                        pulp_rst_no <= 1'b0;
                        fetch_en_o  <= 1'b0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

    // Status word is pure wiring of registered fields
    assign status_o = {run_cnt, 6'b0, lock_lost, lock_tmo, 1'b0, state,
                       1'b0, ret_code, eoc_done};

endmodule

// File: tb/tb_pulp_boot_ctrl.sv
// Directed bench for pulp_boot_ctrl: reset, boot, debounce, abort, lock loss,
// lock timeout, run-counter saturation and status clear.
module tb_pulp_boot_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] ctrl;
    logic        locked;
    logic        eoc;
    logic [1:0]  ret;
    logic        pulp_rst_n;
    logic        fetch_en;
    logic [31:0] status;

    int total = 0;
    int bad   = 0;

    pulp_boot_ctrl dut (
        .ps7_clk      (clk),
        .ps7_rst_n    (rst_n),
        .ctrl_i       (ctrl),
        .clk_locked_i (locked),
        .eoc_i        (eoc),
        .return_i     (ret),
        .pulp_rst_no  (pulp_rst_n),
        .fetch_en_o   (fetch_en),
        .status_o     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From IDLE with lock held: 1 IDLE + 16 hold + 1 lock cycle
    task automatic boot_to_ready();
        ctrl = 32'h8000_0000;
        tick(18);
        chk("ready_rst", {31'b0, pulp_rst_n}, 32'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        ctrl   = 32'h0;
        locked = 1'b0;
        eoc    = 1'b0;
        ret    = 2'b00;

        // Reset and idle
        tick(3);
        chk("rst_status", status, 32'h0);
        chk("rst_prst",   {31'b0, pulp_rst_n}, 32'd0);
        chk("rst_fetch",  {31'b0, fetch_en}, 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk("idle_status", status, 32'h0);
        chk("idle_prst",   {31'b0, pulp_rst_n}, 32'd0);

        // Normal boot
        locked = 1'b1;
        ctrl   = 32'h8000_0000;
        tick(17);
        chk("boot_wait_prst", {31'b0, pulp_rst_n}, 32'd0);
        chk("boot_wait_st",   status, 32'h0000_0020);
        tick(1);
        chk("boot_ready_prst", {31'b0, pulp_rst_n}, 32'd1);
        chk("boot_ready_st",   status, 32'h0000_0030);
        ctrl = 32'h8000_0001;
        tick(31);
        chk("boot_deb31", {31'b0, fetch_en}, 32'd0);
        tick(1);
        chk("boot_fetch", {31'b0, fetch_en}, 32'd1);
        chk("boot_run_st", status, 32'h0000_0040);
        tick(100);
        eoc = 1'b1;
        ret = 2'b10;
        tick(2);
        chk("eoc_sync_lat", status, 32'h0066_0040);
        tick(1);
        chk("eoc_done_st", status, 32'h0066_0055);
        chk("eoc_fetch",   {31'b0, fetch_en}, 32'd0);
        chk("eoc_prst",    {31'b0, pulp_rst_n}, 32'd1);
        eoc = 1'b0;
        ret = 2'b00;
        tick(5);
        chk("done_frozen", status, 32'h0066_0055);

        // Abort from DONE keeps captured bits, then clear
        ctrl = 32'h0;
        tick(1);
        chk("abort_done_st", status, 32'h0066_0005);
        ctrl = 32'h2;
        tick(1);
        chk("clear_idle", status, 32'h0);
        ctrl = 32'h0;
        tick(1);

        // Debounce glitch
        boot_to_ready();
        ctrl = 32'h8000_0001;
        tick(31);
        ctrl = 32'h8000_0000;
        tick(1);
        ctrl = 32'h8000_0001;
        tick(31);
        chk("deb_glitch_fetch", {31'b0, fetch_en}, 32'd0);
        chk("deb_glitch_st",    status, 32'h0000_0030);
        tick(1);
        chk("deb_held_fetch", {31'b0, fetch_en}, 32'd1);

        // Abort mid-run
        tick(10);
        chk("run10_st", status, 32'h000A_0040);
        ctrl = 32'h0;
        tick(1);
        chk("abort_run_prst",  {31'b0, pulp_rst_n}, 32'd0);
        chk("abort_run_fetch", {31'b0, fetch_en}, 32'd0);
        chk("abort_run_st",    status, 32'h000A_0000);
        ctrl = 32'h2;
        tick(1);
        ctrl = 32'h0;
        tick(1);

        // Lock loss and eoc in the same RUN cycle
        boot_to_ready();
        ctrl = 32'h8000_0001;
        tick(32);
        chk("ll_fetch", {31'b0, fetch_en}, 32'd1);
        eoc = 1'b1;
        tick(2);
        locked = 1'b0;
        tick(1);
        chk("ll_status", status, 32'h0002_0260);
        chk("ll_prst",   {31'b0, pulp_rst_n}, 32'd0);
        chk("ll_fetch0", {31'b0, fetch_en}, 32'd0);
        eoc  = 1'b0;
        ctrl = 32'h2;
        tick(1);
        chk("ll_abort_clear", status, 32'h0);
        ctrl = 32'h0;
        tick(1);

        // Lock timeout: 1 IDLE + 16 hold + 1024 wait cycles
        ctrl = 32'h8000_0000;
        tick(1040);
        chk("tmo_wait_st", status, 32'h0000_0020);
        tick(1);
        chk("tmo_err_st", status, 32'h0000_0160);
        chk("tmo_prst",   {31'b0, pulp_rst_n}, 32'd0);
        ctrl = 32'h0;
        tick(1);
        chk("tmo_abort_st", status, 32'h0000_0100);
        ctrl = 32'h2;
        tick(1);
        chk("tmo_clear", status, 32'h0);
        ctrl = 32'h0;
        tick(1);

        // Run counter saturation, then clear while running
        locked = 1'b1;
        boot_to_ready();
        ctrl = 32'h8000_0001;
        tick(32);
        tick(70000);
        chk("sat_st", status, 32'hFFFF_0040);
        ctrl = 32'h8000_0003;
        tick(1);
        chk("sat_clear_st", status, 32'h0000_0040);
        ctrl = 32'h8000_0001;
        tick(1);
        chk("sat_restart_st", status, 32'h0001_0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
